// File: rtl/alu_seq_pkg.sv
// Shared opcode and FSM state definitions for the sequential ALU.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3,
    OP_MOD = 4'd4,
    OP_XOR = 4'd5,
    OP_AND = 4'd6,
    OP_OR  = 4'd7,
    OP_SHR = 4'd8,
    OP_SHL = 4'd9
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Opcodes at or above this value are rejected with err=1.
  localparam logic [3:0] OP_ILLEGAL_MIN = 4'd10;

  // True for the ops that need the iterative divider.
  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_seq_div.sv
// Restoring divider: one quotient bit per cycle, WIDTH cycles after i_start.
// o_done_c pulses on the final iteration cycle with o_quo_c/o_rem_c holding
// the finished values, so the caller can register them on that same edge.
module alu_seq_div
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done_c,
  output logic [WIDTH-1:0] o_quo_c,
  output logic [WIDTH-1:0] o_rem_c
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic             w_last;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    w_shift   = {r_rem, r_quo[WIDTH-1]};
    w_ge      = (w_shift >= {1'b0, r_div});
    w_diff    = w_shift[WIDTH-1:0] - r_div;
    w_rem_nxt = w_ge ? w_diff : w_shift[WIDTH-1:0];
    w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};
    w_last    = r_busy && (r_cnt == CNT_W'(WIDTH - 1));
  end

  // Iteration registers; quotient bits shift in where dividend bits shift out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_rem  <= '0;
      r_quo  <= i_a;
      r_div  <= i_b;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_busy   = r_busy;
  assign o_done_c = w_last;
  assign o_quo_c  = w_quo_nxt;
  assign o_rem_c  = w_rem_nxt;

endmodule

// File: rtl/alu_seq_unit.sv
// Sequential ALU: one opcode-selected op per valid/ready transaction.
// Single-cycle ops complete on the accept edge; DIV/MOD with a non-zero
// divisor run through an iterative divider when ALU_DIV_EN is defined.
// Without ALU_DIV_EN the divider and BUSY path are not built and DIV/MOD
// return 0 with err=1 in one cycle.
module alu_seq_unit
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SH_BITS = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_carry,
  output logic             out_err
);

  localparam int unsigned            SHC_W    = SH_BITS + 1;
  localparam logic [SHC_W-1:0]       SH_LIMIT = SHC_W'(WIDTH);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_y;
  logic             r_carry;
  logic             r_err;

  logic             w_accept;
  logic             w_load;
  logic [WIDTH-1:0] w_ld_y;
  logic             w_ld_carry;
  logic             w_ld_err;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_mul;
  logic             w_sh_oor;
  logic [WIDTH-1:0] w_sc_y;
  logic             w_sc_carry;
  logic             w_sc_err;

`ifdef ALU_DIV_EN
  logic             w_div_start;
  logic             w_div_busy;
  logic             w_div_done;
  logic [WIDTH-1:0] w_div_quo;
  logic [WIDTH-1:0] w_div_rem;
  logic             r_is_mod;

  alu_seq_div #(
    .WIDTH (WIDTH)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_div_start),
    .i_a      (in_a),
    .i_b      (in_b),
    .o_busy   (w_div_busy),
    .o_done_c (w_div_done),
    .o_quo_c  (w_div_quo),
    .o_rem_c  (w_div_rem)
  );

  // Remember whether the running division should return the remainder.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_mod <= 1'b0;
    end else if (w_div_start) begin
      r_is_mod <= (in_op == OP_MOD);
    end
  end
`endif

  assign in_ready = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign w_accept = in_valid && in_ready;

  // Single-cycle datapath, including the divide-by-zero and disabled-divider results.
  always_comb begin
    w_sum      = {1'b0, in_a} + {1'b0, in_b};
    w_mul      = in_a * in_b;
    w_sh_oor   = (|in_b[WIDTH-1:SH_BITS]) || ({1'b0, in_b[SH_BITS-1:0]} >= SH_LIMIT);
    w_sc_y     = '0;
    w_sc_carry = 1'b0;
    w_sc_err   = 1'b0;
    if (in_op >= OP_ILLEGAL_MIN) begin
      w_sc_err = 1'b1;
    end else begin
      case (in_op)
        OP_ADD: begin
          w_sc_y     = w_sum[WIDTH-1:0];
          w_sc_carry = w_sum[WIDTH];
        end
        OP_SUB: begin
          w_sc_y     = in_a - in_b;
          w_sc_carry = (in_a < in_b);
        end
        OP_MUL: w_sc_y = w_mul;
        OP_DIV: begin
`ifdef ALU_DIV_EN
          w_sc_y = '1;
`endif
          w_sc_err = 1'b1;
        end
        OP_MOD: begin
`ifdef ALU_DIV_EN
          w_sc_y = in_a;
`endif
          w_sc_err = 1'b1;
        end
        OP_XOR: w_sc_y = in_a ^ in_b;
        OP_AND: w_sc_y = in_a & in_b;
        OP_OR:  w_sc_y = in_a | in_b;
        OP_SHR: w_sc_y = w_sh_oor ? '0 : (in_a >> in_b[SH_BITS-1:0]);
        OP_SHL: w_sc_y = w_sh_oor ? '0 : (in_a << in_b[SH_BITS-1:0]);
        default: w_sc_err = 1'b1;
      endcase
    end
  end

  // Next-state and result-load decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_ld_y      = w_sc_y;
    w_ld_carry  = w_sc_carry;
    w_ld_err    = w_sc_err;
`ifdef ALU_DIV_EN
    w_div_start = 1'b0;
`endif
    case (r_state)
      IDLE, DONE: begin
        if (w_accept) begin
`ifdef ALU_DIV_EN
          if (is_div_op(in_op) && (in_b != '0)) begin
            w_state_nxt = BUSY;
            w_div_start = 1'b1;
          end else
`endif
          begin
            w_state_nxt = DONE;
            w_load      = 1'b1;
          end
        end else if ((r_state == DONE) && out_ready) begin
          w_state_nxt = IDLE;
        end
      end
`ifdef ALU_DIV_EN
      BUSY: begin
        if (w_div_done) begin
          w_state_nxt = DONE;
          w_load      = 1'b1;
          w_ld_y      = r_is_mod ? w_div_rem : w_div_quo;
          w_ld_carry  = 1'b0;
          w_ld_err    = 1'b0;
        end else if (!w_div_busy) begin
          // Divider idle while BUSY: recover rather than wait forever.
          w_state_nxt = IDLE;
        end
      end
`endif
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output registers; the result only changes when a new one is loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_carry     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_out_valid <= (w_state_nxt == DONE);
      if (w_load) begin
        r_y     <= w_ld_y;
        r_carry <= w_ld_carry;
        r_err   <= w_ld_err;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_y     = r_y;
  assign out_carry = r_carry;
  assign out_err   = r_err;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Bench for alu_seq_unit: behavioural transaction model plus directed vectors.
module tb_alu_seq_unit;

  localparam int unsigned W = 32;
`ifdef ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_y;
  logic         out_carry;
  logic         out_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [W-1:0] y;
    logic         c;
    logic         e;
    int           due;
  } exp_t;

  exp_t q[$];

  logic [W-1:0] sa [2] = '{32'hF0F0_1234, 32'h0000_0007};
  logic [W-1:0] sb [2] = '{32'd5, 32'hFFFF_FFF0};

  alu_seq_unit #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_carry (out_carry),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Result of one operation from the arithmetic rules, using wide integers.
  function automatic void model_res(input logic [3:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b, output logic [W-1:0] y,
                                    output logic c, output logic e);
    logic [63:0] wide;
    y = '0; c = 1'b0; e = 1'b0; wide = '0;
    case (op)
      4'd0: begin wide = 64'(a) + 64'(b); y = wide[W-1:0]; c = wide[W]; end
      4'd1: begin y = a - b; c = (a < b); end
      4'd2: begin wide = 64'(a) * 64'(b); y = wide[W-1:0]; end
      4'd3: begin
        if (!DIV_EN) e = 1'b1;
        else if (b == 0) begin y = '1; e = 1'b1; end
        else y = a / b;
      end
      4'd4: begin
        if (!DIV_EN) e = 1'b1;
        else if (b == 0) begin y = a; e = 1'b1; end
        else y = a % b;
      end
      4'd5: y = a ^ b;
      4'd6: y = a & b;
      4'd7: y = a | b;
      4'd8: y = (b >= W) ? '0 : (a >> b);
      4'd9: y = (b >= W) ? '0 : (a << b);
      default: e = 1'b1;
    endcase
  endfunction

  function automatic bit exp_valid();
    return (q.size() > 0) && (cyc >= q[0].due);
  endfunction

  function automatic bit exp_ready();
    return (q.size() == 0) || (exp_valid() && out_ready);
  endfunction

  // Transaction model: pending result with the cycle it becomes visible.
  task automatic model_loop();
    forever begin
      @(posedge clk);
      if (rst) begin
        q.delete();
      end else begin
        bit   vld;
        bit   rdy;
        int   lat;
        exp_t e;
        vld = exp_valid();
        rdy = exp_ready();
        if (vld && out_ready) void'(q.pop_front());
        if (in_valid && rdy) begin
          model_res(in_op, in_a, in_b, e.y, e.c, e.e);
          lat = (DIV_EN && (in_op == 4'd3 || in_op == 4'd4) && in_b != 0) ? int'(W) + 1 : 1;
          e.due = cyc + lat;
          q.push_back(e);
        end
      end
      cyc++;
    end
  endtask

  // Per-cycle comparison of the DUT against the model.
  task automatic cmp_loop();
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_out_y", out_y, W'(0));
        chk("rst_out_carry", W'(out_carry), W'(0));
        chk("rst_out_err", W'(out_err), W'(0));
      end else begin
        chk("out_valid", W'(out_valid), W'(exp_valid()));
        chk("in_ready", W'(in_ready), W'(exp_ready()));
        if (exp_valid()) begin
          chk("out_y", out_y, q[0].y);
          chk("out_carry", W'(out_carry), W'(q[0].c));
          chk("out_err", W'(out_err), W'(q[0].e));
        end
      end
    end
  endtask

  // Issue one op from idle and wait for its result; optionally pin literal values.
  task automatic do_op(input string nm, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] ey, input logic ec,
                       input logic ee, input int elat, input int elow, input bit lit);
    int lat;
    int low;
    int guard;
    bit acc;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    guard = 0; acc = 1'b0;
    while (!acc && guard < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      guard++;
    end
    #1 in_valid = 1'b0;
    if (!acc) chk({nm, "_accept"}, W'(0), W'(1));
    lat = 0; low = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!in_ready) low++;
    end while (!out_valid && lat < 200);
    if (lit) begin
      chk({nm, "_latency"}, W'(lat), W'(elat));
      chk({nm, "_ready_low"}, W'(low), W'(elow));
      chk({nm, "_y"}, out_y, ey);
      chk({nm, "_carry"}, W'(out_carry), W'(ec));
      chk({nm, "_err"}, W'(out_err), W'(ee));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] bb_y [3];
    logic         bb_v [3];
    logic         bb_c;
    int           stale;
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b1;
    fork
      model_loop();
      cmp_loop();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", W'(out_valid), W'(0));
    chk("reset_y", out_y, W'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", W'(in_ready), W'(1));
    @(posedge clk);
    #1;

    do_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1, 0, 1'b1);

    // Back-to-back SUB, SHR, SHL with out_ready high.
    in_valid = 1'b1; in_op = 4'd1; in_a = 32'd5; in_b = 32'd7;
    @(posedge clk);
    #1 in_op = 4'd8; in_a = 32'h80; in_b = 32'd4;
    @(negedge clk);
    bb_v[0] = out_valid; bb_y[0] = out_y; bb_c = out_carry;
    @(posedge clk);
    #1 in_op = 4'd9; in_a = 32'd1; in_b = 32'd40;
    @(negedge clk);
    bb_v[1] = out_valid; bb_y[1] = out_y;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    bb_v[2] = out_valid; bb_y[2] = out_y;
    chk("b2b_sub_y", bb_y[0], 32'hFFFF_FFFE);
    chk("b2b_sub_carry", W'(bb_c), W'(1));
    chk("b2b_shr_y", bb_y[1], 32'h8);
    chk("b2b_shl_y", bb_y[2], 32'h0);
    chk("b2b_valid_run", W'({bb_v[0], bb_v[1], bb_v[2]}), W'(3'b111));
    @(posedge clk);
    #1;

    do_op("div", 4'd3, 32'd100, 32'd7, DIV_EN ? 32'd14 : 32'd0, 1'b0, !DIV_EN,
          DIV_EN ? int'(W) + 1 : 1, DIV_EN ? int'(W) : 0, 1'b1);
    do_op("mod", 4'd4, 32'd100, 32'd7, DIV_EN ? 32'd2 : 32'd0, 1'b0, !DIV_EN,
          DIV_EN ? int'(W) + 1 : 1, DIV_EN ? int'(W) : 0, 1'b1);
    do_op("div0", 4'd3, 32'd9, 32'd0, DIV_EN ? 32'hFFFF_FFFF : 32'd0, 1'b0, 1'b1, 1, 0, 1'b1);
    do_op("mod0", 4'd4, 32'd9, 32'd0, DIV_EN ? 32'd9 : 32'd0, 1'b0, 1'b1, 1, 0, 1'b1);
    do_op("illegal", 4'd12, 32'd5, 32'd6, 32'd0, 1'b0, 1'b1, 1, 0, 1'b1);

    // Backpressure: MUL result held while a second op waits.
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 4'd2; in_a = 32'd3; in_b = 32'd4;
    @(posedge clk);
    #1 in_op = 4'd0; in_a = 32'd1; in_b = 32'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", W'(out_valid), W'(1));
      chk("bp_y", out_y, 32'd12);
      chk("bp_in_ready", W'(in_ready), W'(0));
      @(posedge clk);
    end
    #1 in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset ten cycles into a division.
    in_valid = 1'b1; in_op = 4'd3; in_a = 32'd100; in_b = 32'd7;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", W'(out_valid), W'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", W'(in_ready), W'(1));
    stale = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) stale++;
      @(negedge clk);
    end
    chk("midrst_stale", W'(stale), W'(0));
    @(posedge clk);
    #1;
    do_op("post_rst_add", 4'd0, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0, 1, 0, 1'b1);

    // Sweep every opcode over a couple of operand pairs against the model.
    for (int op = 0; op < 16; op++) begin
      for (int k = 0; k < 2; k++) begin
        do_op("sweep", 4'(op), sa[k], sb[k], '0, 1'b0, 1'b0, 0, 0, 1'b0);
      end
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (tests %0d, failed %0d)", n_tests, n_fail);
    $fatal(1);
  end

endmodule
